// File: rtl/alu_bus_driver.sv
// Purpose: host-side sequencer driving the ALU BEGIN/op_code/inbus/outbus/END bus, one command at a time.
// Latency: accept -> rsp_valid = 1 (START) + 2 or 3 (SEND) + ALU cycles until END rises + 1.
// Backpressure: cmd_ready only in IDLE; the response is held stable in RESP until rsp_ready is seen.
module alu_bus_driver #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [2*WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 BEGIN,
  output logic [1:0]           op_code,
  output logic [WIDTH-1:0]     inbus,
  input  logic [WIDTH-1:0]     outbus,
  input  logic                 END
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_SEND0 = 3'd2;
  localparam logic [2:0] S_SEND1 = 3'd3;
  localparam logic [2:0] S_SEND2 = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_RESP  = 3'd6;

  logic [2:0]         state_q,    state_d;
  logic [1:0]         op_q,       op_d;
  logic [2*WIDTH-1:0] a_q,        a_d;
  logic [WIDTH-1:0]   b_q,        b_d;
  logic               begin_q,    begin_d;
  logic [1:0]         opcode_q,   opcode_d;
  logic [WIDTH-1:0]   inbus_q,    inbus_d;
  logic [WIDTH-1:0]   h0_q,       h0_d;
  logic [WIDTH-1:0]   h1_q,       h1_d;
  logic               end_dly_q,  end_dly_d;
  logic [CW-1:0]      cnt_q,      cnt_d;
  logic               rvalid_q,   rvalid_d;
  logic [2*WIDTH-1:0] rdata_q,    rdata_d;
  logic               rerr_q,     rerr_d;

  logic is_div;
  assign is_div = (op_q == 2'b11);

  // Next-state logic: command sequencing, operand streaming, END-edge capture and timeout.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    begin_d   = 1'b0;
    opcode_d  = opcode_q;
    inbus_d   = '0;
    h0_d      = h0_q;
    h1_d      = h1_q;
    end_dly_d = end_dly_q;
    cnt_d     = cnt_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rerr_d    = rerr_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d  = S_START;
          op_d     = cmd_op;
          a_d      = cmd_a;
          b_d      = cmd_b;
          begin_d  = 1'b1;
          opcode_d = cmd_op;
        end
      end
      S_START: begin
        state_d   = S_SEND0;
        inbus_d   = is_div ? a_q[2*WIDTH-1:WIDTH] : a_q[WIDTH-1:0];
        end_dly_d = END;
      end
      S_SEND0: begin
        state_d   = S_SEND1;
        inbus_d   = is_div ? a_q[WIDTH-1:0] : b_q;
        end_dly_d = END;
        cnt_d     = '0;
      end
      S_SEND1: begin
        // END sampled in the last SEND cycle preloads the edge detector,
        // so an END left high by the previous operation is not mistaken for completion.
        state_d   = is_div ? S_SEND2 : S_WAIT;
        inbus_d   = is_div ? b_q : '0;
        end_dly_d = END;
        cnt_d     = '0;
      end
      S_SEND2: begin
        state_d   = S_WAIT;
        end_dly_d = END;
        cnt_d     = '0;
      end
      S_WAIT: begin
        h1_d      = h0_q;
        h0_d      = outbus;
        end_dly_d = END;
        cnt_d     = cnt_q + 1'b1;
        // END rise has priority over a coincident timeout.
        if (END && !end_dly_q) begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
          rdata_d  = {h1_q, h0_q};
          rerr_d   = 1'b0;
          opcode_d = 2'b00;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
          rdata_d  = '0;
          rerr_d   = 1'b1;
          opcode_d = 2'b00;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d  = S_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        opcode_d = 2'b00;
        rvalid_d = 1'b0;
      end
    endcase
  end

  // State and registered bus/response outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      a_q       <= '0;
      b_q       <= '0;
      begin_q   <= 1'b0;
      opcode_q  <= 2'b00;
      inbus_q   <= '0;
      h0_q      <= '0;
      h1_q      <= '0;
      end_dly_q <= 1'b0;
      cnt_q     <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      begin_q   <= begin_d;
      opcode_q  <= opcode_d;
      inbus_q   <= inbus_d;
      h0_q      <= h0_d;
      h1_q      <= h1_d;
      end_dly_q <= end_dly_d;
      cnt_q     <= cnt_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rerr_q    <= rerr_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign BEGIN     = begin_q;
  assign op_code   = opcode_q;
  assign inbus     = inbus_q;
  assign rsp_valid = rvalid_q;
  assign rsp_data  = rdata_q;
  assign rsp_err   = rerr_q;

endmodule
